// File: rtl/gpi_poll_ctrl.sv
// rtl/gpi_poll_ctrl.sv - APB master that programs the GPI control register and polls its input data register
module gpi_poll_ctrl #(
  parameter int POLL_DIV = 1000,
  parameter int TIMEOUT  = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [2:0]  PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        en,
  input  logic [7:0]  cr_cfg,
  input  logic        cfg_upd,
  input  logic [7:0]  chg_clr,
  output logic [7:0]  gpi_val,
  output logic [7:0]  chg_flags,
  output logic        irq,
  output logic        err,
  output logic        busy
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR_SETUP = 3'd1;
  localparam logic [2:0] S_WR_ACC   = 3'd2;
  localparam logic [2:0] S_RD_SETUP = 3'd3;
  localparam logic [2:0] S_RD_ACC   = 3'd4;
  localparam logic [2:0] S_WAIT     = 3'd5;

  localparam int TW = $clog2(POLL_DIV + 1);
  localparam int AW = $clog2(TIMEOUT + 1);

  localparam logic [TW-1:0] TIMER_LOAD = TW'(POLL_DIV - 1);
  localparam logic [AW-1:0] ACC_LIMIT  = AW'(TIMEOUT);
  localparam logic [2:0]    ADDR_CR    = 3'h0;
  localparam logic [2:0]    ADDR_IDR   = 3'h4;

  logic [2:0]    state;
  logic [7:0]    cr_q;
  logic          cfg_pend;
  logic          cr_retry;   // last CR write timed out; redo it after WAIT
  logic          base_valid; // a sample since the last CR write exists to compare against
  logic [TW-1:0] timer;
  logic [AW-1:0] acc_cnt;
  logic [7:0]    sample;
  logic          sample_fire;
  logic          wr_done;
  logic          prdata_unused;

  // Disabled IDR bits read as Z/X, so everything goes through the programmed mask.
  assign sample        = PRDATA[7:0] & cr_q;
  assign sample_fire   = (state == S_RD_ACC) && PREADY;
  assign wr_done       = (state == S_WR_ACC) && PREADY;
  assign prdata_unused = ^PRDATA[31:8];

  // Bus sequencer: state, registered APB outputs, poll timer and access timeout.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state    <= S_IDLE;
      PSEL     <= 1'b0;
      PENABLE  <= 1'b0;
      PWRITE   <= 1'b0;
      PADDR    <= '0;
      PWDATA   <= '0;
      cr_q     <= '0;
      cfg_pend <= 1'b0;
      cr_retry <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      timer    <= '0;
      acc_cnt  <= '0;
    end else begin
      if (cfg_upd) cfg_pend <= 1'b1;
      case (state)
        S_IDLE: begin
          if (en) begin
            state    <= S_WR_SETUP;
            cr_q     <= cr_cfg;
            cfg_pend <= cfg_upd;
            cr_retry <= 1'b0;
            PSEL     <= 1'b1;
            PENABLE  <= 1'b0;
            PWRITE   <= 1'b1;
            PADDR    <= ADDR_CR;
            PWDATA   <= {24'h0, cr_cfg};
            busy     <= 1'b1;
          end
        end
        S_WR_SETUP: begin
          state   <= S_WR_ACC;
          PENABLE <= 1'b1;
          acc_cnt <= AW'(1);
        end
        S_WR_ACC: begin
          if (PREADY) begin
            cr_retry <= 1'b0;
            PENABLE  <= 1'b0;
            if (!en) begin
              state <= S_IDLE;
              PSEL  <= 1'b0;
              busy  <= 1'b0;
            end else begin
              state  <= S_RD_SETUP;
              PWRITE <= 1'b0;
              PADDR  <= ADDR_IDR;
            end
          end else if (acc_cnt == ACC_LIMIT) begin
            state    <= S_WAIT;
            err      <= 1'b1;
            cr_retry <= 1'b1;
            PSEL     <= 1'b0;
            PENABLE  <= 1'b0;
            timer    <= TIMER_LOAD;
          end else begin
            acc_cnt <= acc_cnt + AW'(1);
          end
        end
        S_RD_SETUP: begin
          state   <= S_RD_ACC;
          PENABLE <= 1'b1;
          acc_cnt <= AW'(1);
        end
        S_RD_ACC: begin
          if (PREADY) begin
            PENABLE <= 1'b0;
            if (!en) begin
              state <= S_IDLE;
              PSEL  <= 1'b0;
              busy  <= 1'b0;
            end else if (cfg_pend) begin
              state    <= S_WR_SETUP;
              cr_q     <= cr_cfg;
              cfg_pend <= cfg_upd;
              PWRITE   <= 1'b1;
              PADDR    <= ADDR_CR;
              PWDATA   <= {24'h0, cr_cfg};
            end else begin
              state <= S_WAIT;
              PSEL  <= 1'b0;
              timer <= TIMER_LOAD;
            end
          end else if (acc_cnt == ACC_LIMIT) begin
            state   <= S_WAIT;
            err     <= 1'b1;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            timer   <= TIMER_LOAD;
          end else begin
            acc_cnt <= acc_cnt + AW'(1);
          end
        end
        S_WAIT: begin
          if (!en) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (cfg_pend) begin
            state    <= S_WR_SETUP;
            cr_q     <= cr_cfg;
            cfg_pend <= cfg_upd;
            PSEL     <= 1'b1;
            PWRITE   <= 1'b1;
            PADDR    <= ADDR_CR;
            PWDATA   <= {24'h0, cr_cfg};
          end else if (timer == '0) begin
            PSEL <= 1'b1;
            if (cr_retry) begin
              state  <= S_WR_SETUP;
              PWRITE <= 1'b1;
              PADDR  <= ADDR_CR;
              PWDATA <= {24'h0, cr_q};
            end else begin
              state  <= S_RD_SETUP;
              PWRITE <= 1'b0;
              PADDR  <= ADDR_IDR;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: begin
          state   <= S_IDLE;
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Sample capture, sticky change flags (set beats clear) and the registered interrupt.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      gpi_val    <= '0;
      chg_flags  <= '0;
      irq        <= 1'b0;
      base_valid <= 1'b0;
    end else begin
      irq <= |chg_flags;
      if (wr_done) base_valid <= 1'b0;
      if (sample_fire) begin
        gpi_val <= sample;
        if (base_valid) begin
          chg_flags <= (chg_flags & ~chg_clr) | (sample ^ gpi_val);
        end else begin
          base_valid <= 1'b1;
          chg_flags  <= chg_flags & ~chg_clr;
        end
      end else begin
        chg_flags <= chg_flags & ~chg_clr;
      end
    end
  end

endmodule

// File: tb/tb_gpi_poll_ctrl.sv
// tb/tb_gpi_poll_ctrl.sv - directed bench for gpi_poll_ctrl with a small APB slave model
module tb_gpi_poll_ctrl;

  logic        PCLK;
  logic        PRESET;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [2:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        en;
  logic [7:0]  cr_cfg;
  logic        cfg_upd;
  logic [7:0]  chg_clr;
  logic [7:0]  gpi_val;
  logic [7:0]  chg_flags;
  logic        irq;
  logic        err;
  logic        busy;

  logic [7:0]  gpi_in;
  int          mode;     // 0: one wait state, 1: zero wait, 2: never ready
  logic        acc_cyc;
  int          checks;
  int          errors;

  gpi_poll_ctrl #(.POLL_DIV(4), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .en(en),
    .cr_cfg(cr_cfg), .cfg_upd(cfg_upd), .chg_clr(chg_clr), .gpi_val(gpi_val),
    .chg_flags(chg_flags), .irq(irq), .err(err), .busy(busy)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Slave: ready one cycle after it first sees PSEL & PENABLE (mode 0).
  always @(posedge PCLK) acc_cyc <= PSEL && PENABLE && !PREADY;
  assign PREADY = PSEL && PENABLE && ((mode == 1) || (mode == 0 && acc_cyc));
  assign PRDATA = {24'hA5C3E1, gpi_in};

  typedef struct {
    logic       en;
    logic [7:0] clr;
    logic [7:0] gpi;
    logic       psel;
    logic       pen;
    logic       pwr;
    logic [2:0] paddr;
    logic [7:0] gval;
    logic [7:0] chg;
    logic       irq;
  } vec_t;

  vec_t vt[22];

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic wait_rd();
    int n;
    n = 0;
    while (!(PSEL && PENABLE && PREADY && !PWRITE) && n < 100) begin
      tick();
      n++;
    end
    chk("wait_rd_bound", 32'(n < 100), 32'd1);
    tick();
  endtask

  task automatic wait_racc();
    int n;
    n = 0;
    while (!(PSEL && PENABLE && !PREADY && !PWRITE) && n < 100) begin
      tick();
      n++;
    end
    chk("wait_racc_bound", 32'(n < 100), 32'd1);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    mode    = 0;
    acc_cyc = 1'b0;
    PRESET  = 1'b1;
    en      = 1'b0;
    cr_cfg  = 8'hFF;
    cfg_upd = 1'b0;
    chg_clr = 8'h00;
    gpi_in  = 8'h00;

    vt[0]  = '{1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 3'h0, 8'h00, 8'h00, 1'b0};
    vt[1]  = '{1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 3'h0, 8'h00, 8'h00, 1'b0};
    vt[2]  = '{1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 3'h0, 8'h00, 8'h00, 1'b0};
    vt[3]  = '{1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 3'h4, 8'h00, 8'h00, 1'b0};
    vt[4]  = '{1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 3'h4, 8'h00, 8'h00, 1'b0};
    vt[5]  = '{1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 3'h4, 8'h00, 8'h00, 1'b0};
    vt[6]  = '{1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'h4, 8'h00, 8'h00, 1'b0};
    vt[7]  = '{1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'h4, 8'h00, 8'h00, 1'b0};
    vt[8]  = '{1'b1, 8'h00, 8'h05, 1'b0, 1'b0, 1'b0, 3'h4, 8'h00, 8'h00, 1'b0};
    vt[9]  = '{1'b1, 8'h00, 8'h05, 1'b0, 1'b0, 1'b0, 3'h4, 8'h00, 8'h00, 1'b0};
    vt[10] = '{1'b1, 8'h00, 8'h05, 1'b1, 1'b0, 1'b0, 3'h4, 8'h00, 8'h00, 1'b0};
    vt[11] = '{1'b1, 8'h00, 8'h05, 1'b1, 1'b1, 1'b0, 3'h4, 8'h00, 8'h00, 1'b0};
    vt[12] = '{1'b1, 8'h00, 8'h05, 1'b1, 1'b1, 1'b0, 3'h4, 8'h00, 8'h00, 1'b0};
    vt[13] = '{1'b1, 8'h00, 8'h05, 1'b0, 1'b0, 1'b0, 3'h4, 8'h05, 8'h05, 1'b0};
    vt[14] = '{1'b1, 8'h01, 8'h05, 1'b0, 1'b0, 1'b0, 3'h4, 8'h05, 8'h04, 1'b1};
    vt[15] = '{1'b1, 8'h04, 8'h05, 1'b0, 1'b0, 1'b0, 3'h4, 8'h05, 8'h00, 1'b1};
    vt[16] = '{1'b1, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 3'h4, 8'h05, 8'h00, 1'b0};
    vt[17] = '{1'b1, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 3'h4, 8'h05, 8'h00, 1'b0};
    vt[18] = '{1'b1, 8'h00, 8'h01, 1'b1, 1'b1, 1'b0, 3'h4, 8'h05, 8'h00, 1'b0};
    vt[19] = '{1'b1, 8'h00, 8'h01, 1'b1, 1'b1, 1'b0, 3'h4, 8'h05, 8'h00, 1'b0};
    vt[20] = '{1'b1, 8'h04, 8'h01, 1'b0, 1'b0, 1'b0, 3'h4, 8'h01, 8'h04, 1'b0};
    vt[21] = '{1'b1, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 3'h4, 8'h01, 8'h04, 1'b1};

    tick();
    tick();
    chk("rst_psel", 32'(PSEL), 32'd0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    chk("rst_pwrite", 32'(PWRITE), 32'd0);
    chk("rst_paddr", 32'(PADDR), 32'd0);
    chk("rst_pwdata", PWDATA, 32'd0);
    chk("rst_gpi_val", 32'(gpi_val), 32'd0);
    chk("rst_chg", 32'(chg_flags), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    PRESET = 1'b0;

    for (int i = 0; i < 22; i++) begin
      en      = vt[i].en;
      chg_clr = vt[i].clr;
      gpi_in  = vt[i].gpi;
      tick();
      chk($sformatf("v%0d_psel", i), 32'(PSEL), 32'(vt[i].psel));
      chk($sformatf("v%0d_penable", i), 32'(PENABLE), 32'(vt[i].pen));
      chk($sformatf("v%0d_pwrite", i), 32'(PWRITE), 32'(vt[i].pwr));
      chk($sformatf("v%0d_paddr", i), 32'(PADDR), 32'(vt[i].paddr));
      chk($sformatf("v%0d_pwdata", i), PWDATA, 32'h0000_00FF);
      chk($sformatf("v%0d_gpi_val", i), 32'(gpi_val), 32'(vt[i].gval));
      chk($sformatf("v%0d_chg", i), 32'(chg_flags), 32'(vt[i].chg));
      chk($sformatf("v%0d_irq", i), 32'(irq), 32'(vt[i].irq));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
      chk($sformatf("v%0d_err", i), 32'(err), 32'd0);
    end
    chg_clr = 8'h00;

    // Mask reprogram from WAIT: upper-nibble toggles must never flag.
    cr_cfg  = 8'h0F;
    cfg_upd = 1'b1;
    chg_clr = 8'hFF;
    tick();
    chk("mask_clr_chg", 32'(chg_flags), 32'd0);
    cfg_upd = 1'b0;
    chg_clr = 8'h00;
    gpi_in  = 8'hF3;
    tick();
    chk("mask_wr_psel", 32'(PSEL), 32'd1);
    chk("mask_wr_pwrite", 32'(PWRITE), 32'd1);
    chk("mask_wr_paddr", 32'(PADDR), 32'd0);
    chk("mask_wr_pwdata", PWDATA, 32'h0000_000F);
    wait_rd();
    chk("mask_base_gval", 32'(gpi_val), 32'h03);
    chk("mask_base_chg", 32'(chg_flags), 32'h00);
    gpi_in = 8'h33;
    wait_rd();
    chk("mask_upper_gval", 32'(gpi_val), 32'h03);
    chk("mask_upper_chg", 32'(chg_flags), 32'h00);
    gpi_in = 8'h37;
    wait_rd();
    chk("mask_lower_gval", 32'(gpi_val), 32'h07);
    chk("mask_lower_chg", 32'(chg_flags), 32'h04);
    chg_clr = 8'hFF;
    tick();
    chg_clr = 8'h00;
    chk("mask_clear", 32'(chg_flags), 32'h00);

    // cfg_upd during a read: read completes, then CR write, then a baseline read.
    wait_racc();
    cr_cfg  = 8'hFF;
    cfg_upd = 1'b1;
    tick();
    cfg_upd = 1'b0;
    wait_rd();
    chk("upd_gval", 32'(gpi_val), 32'h07);
    chk("upd_wr_psel", 32'(PSEL), 32'd1);
    chk("upd_wr_penable", 32'(PENABLE), 32'd0);
    chk("upd_wr_pwrite", 32'(PWRITE), 32'd1);
    chk("upd_wr_paddr", 32'(PADDR), 32'd0);
    chk("upd_wr_pwdata", PWDATA, 32'h0000_00FF);
    wait_rd();
    chk("upd_base_gval", 32'(gpi_val), 32'h37);
    chk("upd_base_chg", 32'(chg_flags), 32'h00);
    gpi_in = 8'h3F;
    wait_rd();
    chk("upd_next_gval", 32'(gpi_val), 32'h3F);
    chk("upd_next_chg", 32'(chg_flags), 32'h08);

    // en dropped during a read: transfer completes, then IDLE.
    wait_racc();
    en = 1'b0;
    wait_rd();
    chk("dis_psel", 32'(PSEL), 32'd0);
    chk("dis_penable", 32'(PENABLE), 32'd0);
    chk("dis_busy", 32'(busy), 32'd0);
    chk("dis_gval", 32'(gpi_val), 32'h3F);
    tick();
    tick();
    chk("dis_idle_psel", 32'(PSEL), 32'd0);
    chk("dis_idle_busy", 32'(busy), 32'd0);

    // Slave never ready: abort after 16 access cycles, err, CR write retried.
    mode = 2;
    en   = 1'b1;
    tick();
    chk("to_setup_psel", 32'(PSEL), 32'd1);
    begin
      int n;
      int guard;
      n     = 0;
      guard = 0;
      while (PSEL && guard < 40) begin
        tick();
        guard++;
        if (PSEL && PENABLE) n++;
      end
      chk("to_acc_cycles", 32'(n), 32'd16);
    end
    chk("to_psel", 32'(PSEL), 32'd0);
    chk("to_penable", 32'(PENABLE), 32'd0);
    chk("to_err", 32'(err), 32'd1);
    chk("to_gval", 32'(gpi_val), 32'h3F);
    chk("to_chg", 32'(chg_flags), 32'h08);
    mode = 0;
    tick();
    tick();
    tick();
    chk("to_wait_psel", 32'(PSEL), 32'd0);
    tick();
    chk("to_retry_psel", 32'(PSEL), 32'd1);
    chk("to_retry_pwrite", 32'(PWRITE), 32'd1);
    chk("to_retry_paddr", 32'(PADDR), 32'd0);
    chk("to_retry_pwdata", PWDATA, 32'h0000_00FF);
    gpi_in = 8'h44;
    wait_rd();
    chk("to_after_gval", 32'(gpi_val), 32'h44);
    chk("to_after_chg", 32'(chg_flags), 32'h08);
    chk("to_err_sticky", 32'(err), 32'd1);

    // Zero-wait-state slave.
    mode   = 1;
    gpi_in = 8'h5A;
    wait_rd();
    chk("zw_gval", 32'(gpi_val), 32'h5A);
    chk("zw_chg", 32'(chg_flags), 32'h1E);

    // Reset in the middle of a CR write.
    mode = 0;
    en   = 1'b0;
    begin
      int guard;
      guard = 0;
      while (busy && guard < 50) begin
        tick();
        guard++;
      end
      chk("rst2_idle_bound", 32'(guard < 50), 32'd1);
    end
    en = 1'b1;
    tick();
    tick();
    chk("rst2_in_wr_acc", 32'(PSEL && PENABLE && PWRITE), 32'd1);
    PRESET = 1'b1;
    tick();
    chk("rst2_psel", 32'(PSEL), 32'd0);
    chk("rst2_penable", 32'(PENABLE), 32'd0);
    chk("rst2_pwrite", 32'(PWRITE), 32'd0);
    chk("rst2_paddr", 32'(PADDR), 32'd0);
    chk("rst2_pwdata", PWDATA, 32'd0);
    chk("rst2_gval", 32'(gpi_val), 32'd0);
    chk("rst2_chg", 32'(chg_flags), 32'd0);
    chk("rst2_irq", 32'(irq), 32'd0);
    chk("rst2_err", 32'(err), 32'd0);
    chk("rst2_busy", 32'(busy), 32'd0);
    PRESET = 1'b0;
    en     = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
